// File: rtl/video_out_dma.sv
// Frame reader: Wishbone burst fetch of NBWORDS words, then big-endian unpack into pixels for the video FIFO.
// Latency: BURST starts two edges after the address edge; one pixel per cycle while the FIFO is not full (full stalls w_e and holds pixel_out).
module video_out_dma #(
  parameter int NBWORDS = 4,
  parameter int BPP     = 1,
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int INT_LEN = 4
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic [31:0]       wb_reg_data,
  input  logic [31:0]       wb_reg_ctr,
  output logic              interrupt,
  input  logic [31:0]       p_wb_DAT_I,
  input  logic              p_wb_ACK_I,
  output logic              p_wb_STB_O,
  output logic              p_wb_CYC_O,
  output logic              p_wb_LOCK_O,
  output logic [3:0]        p_wb_SEL_O,
  output logic              p_wb_WE_O,
  output logic [31:0]       p_wb_ADR_O,
  input  logic              full,
  output logic              w_e,
  output logic [8*BPP-1:0]  pixel_out
);

  localparam int FRAME_BYTES = WIDTH * HEIGHT * BPP;
  localparam int PPW         = 4 / BPP;
  localparam int NPIX        = NBWORDS * PPW;
  localparam int PW          = 8 * BPP;
  localparam int OFF_W       = $clog2(FRAME_BYTES + 1);
  localparam int WC_W        = (NBWORDS > 1) ? $clog2(NBWORDS) : 1;
  localparam int PIX_W       = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int INT_W       = (INT_LEN > 1) ? $clog2(INT_LEN) : 1;
  localparam int SH          = $clog2(PPW);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN, S_DONE} state_t;

  state_t             state;
  logic               ctr0_q;
  logic               pending;
  logic [31:0]        shadow;
  logic [31:0]        base;
  logic [OFF_W-1:0]   offset;
  logic [WC_W-1:0]    word_cnt;
  logic [PIX_W-1:0]   pix_idx;
  logic [INT_W-1:0]   int_cnt;
  logic [31:0]        buf_q [NBWORDS];

  logic               addr_edge;
  logic               last_word;
  logic               last_pix;
  logic [WC_W-1:0]    word_sel;
  logic [1:0]         sub;
  logic [31:0]        shifted;
  logic               unused_ok;

  assign addr_edge = wb_reg_ctr[0] & ~ctr0_q;
  assign last_word = (word_cnt == WC_W'(NBWORDS - 1));
  assign last_pix  = (pix_idx == PIX_W'(NPIX - 1));

  // First pixel of a word sits in the top bits, so shift left by its slot.
  assign word_sel  = WC_W'(pix_idx >> SH);
  assign sub       = 2'(pix_idx) & 2'(PPW - 1);
  assign shifted   = buf_q[word_sel] << (32'(sub) * 32'(PW));
  assign pixel_out = shifted[31 -: PW];

  assign p_wb_CYC_O  = (state == S_BURST);
  assign p_wb_STB_O  = (state == S_BURST);
  assign p_wb_ADR_O  = base + 32'(offset);
  assign p_wb_LOCK_O = 1'b0;
  assign p_wb_SEL_O  = 4'hF;
  assign p_wb_WE_O   = 1'b0;
  assign interrupt   = (state == S_DONE);
  assign w_e         = (state == S_DRAIN) && !full;

  assign unused_ok = ^{wb_reg_ctr[31:3], wb_reg_data[1:0]};

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state    <= S_IDLE;
      ctr0_q   <= 1'b0;
      pending  <= 1'b0;
      shadow   <= '0;
      base     <= '0;
      offset   <= '0;
      word_cnt <= '0;
      pix_idx  <= '0;
      int_cnt  <= '0;
      for (int i = 0; i < NBWORDS; i++) buf_q[i] <= '0;
    end else begin
      ctr0_q <= wb_reg_ctr[0];
      if (wb_reg_ctr[2]) begin
        // Abort wins over everything, including an address edge in the same cycle.
        state    <= S_IDLE;
        offset   <= '0;
        word_cnt <= '0;
        pix_idx  <= '0;
        int_cnt  <= '0;
        pending  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (pending) begin
              base    <= shadow;
              pending <= 1'b0;
              offset  <= '0;
              state   <= S_BURST;
            end
          end
          S_BURST: begin
            if (p_wb_ACK_I) begin
              buf_q[word_cnt] <= p_wb_DAT_I;
              offset          <= offset + OFF_W'(4);
              if (last_word) begin
                word_cnt <= '0;
                state    <= S_DRAIN;
              end else begin
                word_cnt <= word_cnt + WC_W'(1);
              end
            end
          end
          S_DRAIN: begin
            if (!full) begin
              if (last_pix) begin
                pix_idx <= '0;
                if (offset == OFF_W'(FRAME_BYTES)) begin
                  int_cnt <= '0;
                  state   <= S_DONE;
                end else begin
                  state <= S_BURST;
                end
              end else begin
                pix_idx <= pix_idx + PIX_W'(1);
              end
            end
          end
          S_DONE: begin
            if (int_cnt == INT_W'(INT_LEN - 1)) begin
              int_cnt <= '0;
              if (pending) begin
                base    <= shadow;
                pending <= 1'b0;
                offset  <= '0;
                state   <= S_BURST;
              end else if (wb_reg_ctr[1]) begin
                offset <= '0;
                state  <= S_BURST;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              int_cnt <= int_cnt + INT_W'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
        // Placed after the FSM so a fresh edge survives a same-cycle reload.
        if (addr_edge) begin
          shadow  <= {wb_reg_data[31:2], 2'b00};
          pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_video_out_dma.sv
// Directed bench: 16-byte frames (8x2, BPP=1) on one instance, BPP=2 unpacking on a second.
module tb_video_out_dma;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        nRST;
  logic [31:0] reg_data, reg_ctr, rd_dat, adr;
  logic        ack, stb, cyc, lock, we_o, full, we, irq;
  logic [3:0]  sel;
  logic [7:0]  pix;

  logic [31:0] reg_data2, reg_ctr2, rd_dat2, adr2;
  logic        ack2, stb2, cyc2, lock2, we_o2, full2, we2, irq2;
  logic [3:0]  sel2;
  logic [15:0] pix2;

  // Slave memory: the byte at address a holds a[7:0].
  assign rd_dat  = {adr[7:0], adr[7:0] + 8'd1, adr[7:0] + 8'd2, adr[7:0] + 8'd3};
  assign rd_dat2 = 32'hAABBCCDD ^ {adr2[7:0], 8'h00, adr2[7:0], 8'h00};

  video_out_dma #(.NBWORDS(4), .BPP(1), .WIDTH(8), .HEIGHT(2), .INT_LEN(4)) dut (
    .clk(clk), .nRST(nRST), .wb_reg_data(reg_data), .wb_reg_ctr(reg_ctr), .interrupt(irq),
    .p_wb_DAT_I(rd_dat), .p_wb_ACK_I(ack), .p_wb_STB_O(stb), .p_wb_CYC_O(cyc),
    .p_wb_LOCK_O(lock), .p_wb_SEL_O(sel), .p_wb_WE_O(we_o), .p_wb_ADR_O(adr),
    .full(full), .w_e(we), .pixel_out(pix));

  video_out_dma #(.NBWORDS(4), .BPP(2), .WIDTH(4), .HEIGHT(2), .INT_LEN(4)) dut2 (
    .clk(clk), .nRST(nRST), .wb_reg_data(reg_data2), .wb_reg_ctr(reg_ctr2), .interrupt(irq2),
    .p_wb_DAT_I(rd_dat2), .p_wb_ACK_I(ack2), .p_wb_STB_O(stb2), .p_wb_CYC_O(cyc2),
    .p_wb_LOCK_O(lock2), .p_wb_SEL_O(sel2), .p_wb_WE_O(we_o2), .p_wb_ADR_O(adr2),
    .full(full2), .w_e(we2), .pixel_out(pix2));

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] adr_log[$];
  logic [7:0]  pix_log[$];

  always @(negedge clk) begin
    if (cyc && stb && ack) adr_log.push_back(adr);
    if (we) pix_log.push_back(pix);
  end

  typedef struct packed {
    logic [2:0]  ctr;
    logic        full;
    logic        cyc;
    logic [31:0] adr;
    logic        we;
    logic [7:0]  pix;
    logic        irq;
  } vec_t;

  vec_t vt[26];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for the interrupt, measures its length, returns at the first low sample.
  task automatic frame_irq(input string nm);
    int k;
    int hi;
    k = 0;
    while (!irq && k < 300) begin tick(); k++; end
    check({nm, "_irq_seen"}, 32'(irq), 1);
    hi = 0;
    while (irq && hi < 20) begin tick(); hi++; end
    check({nm, "_irq_len"}, 32'(hi), 4);
  endtask

  task automatic check_pixels(input string nm);
    check({nm, "_pix_count"}, 32'(pix_log.size()), 16);
    for (int k = 0; k < 16; k++)
      check({nm, "_pix"}, (k < pix_log.size()) ? 32'(pix_log[k]) : 32'hDEAD, 32'(k));
  endtask

  initial begin
    int k, n, c, n_acc;
    logic [31:0] exp_a;
    logic seen_cyc, seen_irq;
    logic [15:0] exp2[8];
    logic [15:0] got2[8];

    exp2 = '{16'hAABB, 16'hCCDD, 16'hAEBB, 16'hC8DD, 16'hA2BB, 16'hC4DD, 16'hA6BB, 16'hC0DD};
    for (int i = 0; i < 8; i++) got2[i] = 16'h0;

    vt[0] = '{3'd1, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00, 1'b0};
    for (int i = 1; i <= 4; i++)  vt[i] = '{3'd1, 1'b0, 1'b1, 32'h1000 + 32'(4 * (i - 1)), 1'b0, 8'h00, 1'b0};
    for (int i = 5; i <= 20; i++) vt[i] = '{3'd1, 1'b0, 1'b0, 32'h0, 1'b1, 8'(i - 5), 1'b0};
    for (int i = 21; i <= 24; i++) vt[i] = '{3'd1, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00, 1'b1};
    vt[25] = '{3'd1, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00, 1'b0};

    nRST = 1'b0; reg_data = 32'h0; reg_ctr = 32'h0; ack = 1'b0; full = 1'b0;
    reg_data2 = 32'h0; reg_ctr2 = 32'h0; ack2 = 1'b1; full2 = 1'b0;
    tick(); tick();
    check("rst_cyc", 32'(cyc), 0);
    check("rst_stb", 32'(stb), 0);
    check("rst_adr", adr, 32'h0);
    check("rst_irq", 32'(irq), 0);
    check("rst_we", 32'(we), 0);
    check("rst_pix", 32'(pix), 0);
    check("rst_pix2", 32'(pix2), 0);
    check("const_lock", 32'(lock), 0);
    check("const_sel", 32'(sel), 32'hF);
    check("const_we_o", 32'(we_o), 0);
    nRST = 1'b1;
    tick();

    // Basic frame, cycle by cycle.
    reg_data = 32'h1000;
    ack = 1'b1;
    for (int i = 0; i < 26; i++) begin
      reg_ctr = {29'b0, vt[i].ctr};
      full    = vt[i].full;
      tick();
      check($sformatf("tbl_cyc[%0d]", i), 32'(cyc), 32'(vt[i].cyc));
      check($sformatf("tbl_we[%0d]", i), 32'(we), 32'(vt[i].we));
      check($sformatf("tbl_irq[%0d]", i), 32'(irq), 32'(vt[i].irq));
      if (vt[i].cyc) check($sformatf("tbl_adr[%0d]", i), adr, vt[i].adr);
      if (vt[i].we)  check($sformatf("tbl_pix[%0d]", i), 32'(pix), 32'(vt[i].pix));
    end

    // BPP=2 unpacking on the second instance.
    reg_data2 = 32'h3000;
    reg_ctr2  = 32'h1;
    n = 0;
    for (k = 0; k < 60 && !irq2; k++) begin
      tick();
      if (we2 && n < 8) begin got2[n] = pix2; n++; end
    end
    check("b2_irq", 32'(irq2), 1);
    check("b2_count", 32'(n), 8);
    for (int i = 0; i < 8; i++) check("b2_pix", 32'(got2[i]), 32'(exp2[i]));

    // FIFO backpressure in mid-drain.
    reg_ctr = 32'h0; tick();
    reg_ctr = 32'h1; tick();
    k = 0;
    while (!we && k < 40) begin tick(); k++; end
    check("bp_drain_start", 32'(we), 1);
    n = 0;
    for (c = 0; c < 40 && n < 16; c++) begin
      full = (c >= 6 && c < 11);
      #1;
      if (full) begin
        check("bp_we_low", 32'(we), 0);
        check("bp_hold", 32'(pix), 32'(n));
      end else if (we) begin
        check("bp_pix", 32'(pix), 32'(n));
        n++;
      end
      tick();
    end
    full = 1'b0;
    check("bp_count", 32'(n), 16);
    check("bp_irq_after_last", 32'(irq), 1);
    frame_irq("bp");

    // Shadow address taken mid-frame.
    adr_log.delete();
    reg_ctr = 32'h0; tick();
    reg_ctr = 32'h1; tick(); tick();
    check("sh_start_cyc", 32'(cyc), 1);
    check("sh_start_adr", adr, 32'h1000);
    reg_data = 32'h2000; reg_ctr = 32'h0; tick();
    reg_ctr = 32'h1; tick();
    frame_irq("sh1");
    check("sh_next_cyc", 32'(cyc), 1);
    check("sh_next_adr", adr, 32'h2000);
    check("sh_log_size", 32'(adr_log.size()), 4);
    for (int i = 0; i < 4; i++)
      check("sh_log_adr", (i < adr_log.size()) ? adr_log[i] : 32'hDEADBEEF, 32'h1000 + 32'(4 * i));
    frame_irq("sh2");
    check("sh_idle", 32'(cyc), 0);
    check("sh2_first_adr", (adr_log.size() > 4) ? adr_log[4] : 32'hDEADBEEF, 32'h2000);

    // Continuous mode repeats the same base without a new edge.
    adr_log.delete();
    reg_ctr = 32'h0; tick();
    reg_data = 32'h1000; reg_ctr = 32'h3; tick();
    frame_irq("ct1");
    check("ct_restart_cyc", 32'(cyc), 1);
    check("ct_restart_adr", adr, 32'h1000);
    reg_ctr = 32'h1;
    frame_irq("ct2");
    check("ct_idle", 32'(cyc), 0);
    check("ct_log_size", 32'(adr_log.size()), 8);
    check("ct_log4", (adr_log.size() > 4) ? adr_log[4] : 32'hDEADBEEF, 32'h1000);
    check("ct_log7", (adr_log.size() > 7) ? adr_log[7] : 32'hDEADBEEF, 32'h100C);

    // Abort coincident with an address edge drops the edge.
    reg_ctr = 32'h0; tick();
    reg_ctr = 32'h5; tick();
    reg_ctr = 32'h1;
    repeat (4) tick();
    check("ab_edge_dropped", 32'(cyc), 0);

    // Abort mid-burst with ACK low.
    reg_ctr = 32'h0; tick();
    reg_ctr = 32'h1; tick(); tick();
    check("ab_adr0", adr, 32'h1000);
    tick(); tick();
    check("ab_adr2", adr, 32'h1008);
    ack = 1'b0;
    tick();
    check("ab_hold_cyc", 32'(cyc), 1);
    check("ab_hold_adr", adr, 32'h1008);
    tick();
    check("ab_hold_adr2", adr, 32'h1008);
    reg_ctr = 32'h5; tick();
    check("ab_cyc_low", 32'(cyc), 0);
    check("ab_stb_low", 32'(stb), 0);
    reg_ctr = 32'h1; ack = 1'b1;
    seen_cyc = 1'b0; seen_irq = 1'b0;
    repeat (8) begin tick(); seen_cyc |= cyc; seen_irq |= irq; end
    check("ab_stays_idle", 32'(seen_cyc), 0);
    check("ab_no_irq", 32'(seen_irq), 0);
    pix_log.delete();
    reg_ctr = 32'h0; tick();
    reg_ctr = 32'h1; tick(); tick();
    check("ab_restart_cyc", 32'(cyc), 1);
    check("ab_restart_adr", adr, 32'h1000);
    frame_irq("ab");
    check_pixels("ab");

    // Slow slave: ACK every third cycle.
    pix_log.delete();
    ack = 1'b0;
    reg_ctr = 32'h0; tick();
    reg_ctr = 32'h1; tick(); tick();
    check("sl_cyc", 32'(cyc), 1);
    exp_a = 32'h1000; n_acc = 0; k = 0;
    while (n_acc < 4 && k < 40) begin
      ack = ((k % 3) == 2);
      check("sl_stb", 32'(stb), 1);
      check("sl_adr", adr, exp_a);
      tick();
      if (ack) begin exp_a += 32'd4; n_acc++; end
      k++;
    end
    check("sl_drain_cyc", 32'(cyc), 0);
    ack = 1'b1;
    frame_irq("sl");
    check_pixels("sl");

    // Reset in the middle of DRAIN.
    reg_ctr = 32'h0; tick();
    reg_ctr = 32'h1; tick();
    k = 0;
    while (!we && k < 40) begin tick(); k++; end
    check("rs_in_drain", 32'(we), 1);
    repeat (3) tick();
    reg_ctr = 32'h0; nRST = 1'b0;
    tick();
    check("rs_cyc", 32'(cyc), 0);
    check("rs_stb", 32'(stb), 0);
    check("rs_adr", adr, 32'h0);
    check("rs_irq", 32'(irq), 0);
    check("rs_we", 32'(we), 0);
    check("rs_pix", 32'(pix), 0);
    nRST = 1'b1;
    seen_cyc = 1'b0; seen_irq = 1'b0;
    repeat (6) begin tick(); seen_cyc |= cyc; seen_irq |= irq; end
    check("rs_idle_cyc", 32'(seen_cyc), 0);
    check("rs_idle_irq", 32'(seen_irq), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
